vector_ls_sequencer: RTL and testbench
======================================

VECTOR_LS_SEQUENCER -- requirements
Module: vector_ls_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the data-memory word-address width.
REQ-002 The block SHALL have parameter RADDR_W, default 4, giving the vector-register address width.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port reset  input  1  asynchronous active-high reset.
REQ-006 Port req_valid  input  1  a vector LD/ST request is presented.
REQ-007 Port req_ready  output  1  the sequencer can accept a request.
REQ-008 Port req_store  input  1  1 = ST (register to memory), 0 = LD (memory to register).
REQ-009 Port req_base  input  ADDR_W  base memory word address.
REQ-010 Port req_reg  input  RADDR_W  vector register index.
REQ-011 Port req_stride  input  ADDR_W  word stride between columns; present only when VLS_STRIDE_EN is defined.
REQ-012 Port mem_read_address  output  ADDR_W  memory read address for the current LD beat.
REQ-013 Port mem_write_enable  output  1  memory write strobe for the current ST beat.
REQ-014 Port mem_write_address  output  ADDR_W  memory write address for the current ST beat.
REQ-015 Port col_sel  output  2  active 32-bit column (0 = bits 31:0 ... 3 = bits 127:96).
REQ-016 Port reg_write_enable  output  1  register-file column write strobe for the current LD beat.
REQ-017 Port reg_write_address  output  RADDR_W  register written during LD beats.
REQ-018 Port busy  output  1  a request is in progress, from acceptance through the DONE cycle.
REQ-019 Port done  output  1  one-cycle completion pulse.
REQ-020 Port addr_wrap  output  1  valid during done; at least one beat address wrapped modulo 2^ADDR_W.

Function
REQ-021 The FSM SHALL have exactly three states, IDLE, BEAT and DONE, and SHALL enter IDLE on reset.
REQ-022 In IDLE, req_ready SHALL be 1; on a clock edge with req_valid=1 the block SHALL latch req_store, req_base, req_reg and stride, clear the column counter to 0 and the wrap flag, and enter BEAT.
REQ-023 Stride SHALL be req_stride when VLS_STRIDE_EN is defined and the constant 1 otherwise.
REQ-024 In BEAT, the beat address SHALL be (base + col*stride) mod 2^ADDR_W, and col_sel SHALL equal col.
REQ-025 An LD beat SHALL drive mem_read_address = beat address, reg_write_enable = 1, reg_write_address = latched reg, and mem_write_enable = 0.
REQ-026 An ST beat SHALL drive mem_write_enable = 1, mem_write_address = beat address, and reg_write_enable = 0.
REQ-027 Memory read is combinational, so the LD column write SHALL occur on the same edge that ends the beat, giving zero added latency per beat.
REQ-028 col SHALL increment by 1 per BEAT cycle; after the col = 3 beat the FSM SHALL enter DONE, giving exactly 4 beats per request.
REQ-029 The wrap flag SHALL be set if, for any beat, the un-truncated sum base + col*stride is at least 2^ADDR_W; addresses SHALL wrap and SHALL NOT saturate.
REQ-030 In DONE, done SHALL be 1 for exactly one cycle and addr_wrap SHALL present the wrap flag; the FSM SHALL then return to IDLE.
REQ-031 req_ready SHALL be 0 in BEAT and DONE, and req_valid SHALL be ignored there; back-to-back requests therefore start at most every 6 cycles (accept, 4 beats, DONE).
REQ-032 Outside BEAT, mem_write_enable, reg_write_enable, mem_read_address, mem_write_address, reg_write_address and col_sel SHALL all be 0.
REQ-033 Request inputs changing after acceptance SHALL have no effect on an operation in progress.

Reset
REQ-034 Reset SHALL immediately force IDLE, col = 0, wrap flag = 0, req_ready = 1, and busy, done, addr_wrap and all enables, addresses and col_sel = 0.
REQ-035 Reset asserted mid-operation SHALL abort the operation: no further beats and no done pulse.

Configuration
REQ-036 Macro VLS_STRIDE_EN SHALL, when defined, add the req_stride port and per-request programmable stride; when undefined the port SHALL be absent and the stride SHALL be fixed at 1.

Verification
REQ-037 LD request with base = 8'h10 and reg = 3 SHALL produce 4 beats with read addresses 10, 11, 12, 13, col_sel 0..3, reg_write_enable high for each, then done one cycle later.
REQ-038 ST request with base = 8'h20 SHALL produce mem_write_enable for 4 cycles at addresses 20..23 with reg_write_enable = 0, followed by done.
REQ-039 LD request with base = 8'hFE SHALL produce addresses FE, FF, 00, 01, and addr_wrap = 1 with done.
REQ-040 With VLS_STRIDE_EN, an ST request with base = 8'h00 and stride = 8'h04 SHALL produce addresses 00, 04, 08, 0C.
REQ-041 Reset asserted during the col = 1 beat SHALL drop all enables to 0 immediately; done SHALL never assert, and req_ready SHALL be 1 after release.
REQ-042 req_valid held high continuously SHALL yield accepts exactly 6 cycles apart, and a second request's inputs SHALL NOT corrupt the first.

Source files
------------

// File: rtl/vector_ls_sequencer_if.sv
// Request/memory/register-file bundle for the vector load/store sequencer.
// The optional req_stride signal exists only when VLS_STRIDE_EN is defined.
interface vector_ls_sequencer_if #(
  parameter int ADDR_W  = 8,
  parameter int RADDR_W = 4
);
  logic               req_valid;
  logic               req_ready;
  logic               req_store;
  logic [ADDR_W-1:0]  req_base;
  logic [RADDR_W-1:0] req_reg;
`ifdef VLS_STRIDE_EN
  logic [ADDR_W-1:0]  req_stride;
`endif
  logic               mem_write_enable;
  logic [ADDR_W-1:0]  mem_read_address;
  logic [ADDR_W-1:0]  mem_write_address;
  logic [1:0]         col_sel;
  logic               reg_write_enable;
  logic [RADDR_W-1:0] reg_write_address;
  logic               busy;
  logic               done;
  logic               addr_wrap;

  modport master (
`ifdef VLS_STRIDE_EN
    output req_stride,
`endif
    output req_valid, req_store, req_base, req_reg,
    input  req_ready, mem_write_enable, mem_read_address, mem_write_address,
    input  col_sel, reg_write_enable, reg_write_address, busy, done, addr_wrap
  );

  modport slave (
`ifdef VLS_STRIDE_EN
    input  req_stride,
`endif
    input  req_valid, req_store, req_base, req_reg,
    output req_ready, mem_write_enable, mem_read_address, mem_write_address,
    output col_sel, reg_write_enable, reg_write_address, busy, done, addr_wrap
  );
endinterface

// File: rtl/vector_ls_sequencer.sv
// Sequences one 128-bit vector LD/ST as four 32-bit column beats (IDLE -> BEAT x4 -> DONE).
// Define VLS_STRIDE_EN for a per-request word stride; otherwise the stride is fixed at 1.
module vector_ls_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int RADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  vector_ls_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

  state_t             state_reg, state_next;
  logic [1:0]         col_reg;
  logic               store_reg;
  logic               wrap_reg;
  logic [ADDR_W-1:0]  base_reg;
  logic [ADDR_W-1:0]  stride_reg;
  logic [RADDR_W-1:0] reg_reg;
  logic [ADDR_W-1:0]  stride_in;
  logic [ADDR_W+1:0]  beat_sum;
  logic [ADDR_W-1:0]  beat_addr;
  logic               beat_wrap;

`ifdef VLS_STRIDE_EN
  assign stride_in = bus.req_stride;
`else
  assign stride_in = ADDR_W'(1);
`endif

  // Two extra bits hold base + 3*stride exactly, so any carry out marks a wrap.
  assign beat_sum  = {2'b00, base_reg} + ({{ADDR_W{1'b0}}, col_reg} * {2'b00, stride_reg});
  assign beat_addr = beat_sum[ADDR_W-1:0];
  assign beat_wrap = |beat_sum[ADDR_W+1:ADDR_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_reg    <= 2'd0;
      store_reg  <= 1'b0;
      wrap_reg   <= 1'b0;
      base_reg   <= '0;
      stride_reg <= '0;
      reg_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            col_reg    <= 2'd0;
            store_reg  <= bus.req_store;
            wrap_reg   <= 1'b0;
            base_reg   <= bus.req_base;
            stride_reg <= stride_in;
            reg_reg    <= bus.req_reg;
          end
        end
        BEAT: begin
          col_reg  <= col_reg + 2'd1;
          wrap_reg <= wrap_reg | beat_wrap;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from state only, so an asynchronous reset clears them at once.
  always_comb begin
    state_next            = state_reg;
    bus.req_ready         = 1'b0;
    bus.busy              = 1'b0;
    bus.done              = 1'b0;
    bus.addr_wrap         = 1'b0;
    bus.mem_write_enable  = 1'b0;
    bus.mem_read_address  = '0;
    bus.mem_write_address = '0;
    bus.col_sel           = 2'd0;
    bus.reg_write_enable  = 1'b0;
    bus.reg_write_address = '0;
    case (state_reg)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_next = BEAT;
      end
      BEAT: begin
        bus.busy    = 1'b1;
        bus.col_sel = col_reg;
        if (store_reg) begin
          bus.mem_write_enable  = 1'b1;
          bus.mem_write_address = beat_addr;
        end else begin
          bus.mem_read_address  = beat_addr;
          bus.reg_write_enable  = 1'b1;
          bus.reg_write_address = reg_reg;
        end
        if (col_reg == 2'd3) state_next = DONE;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.done      = 1'b1;
        bus.addr_wrap = wrap_reg;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_vector_ls_sequencer.sv
// Bench for vector_ls_sequencer: directed and random requests checked against an
// arithmetic model of the beat addresses and wrap flag; honours VLS_STRIDE_EN.
module tb_vector_ls_sequencer;
  localparam int AW = 8;
  localparam int RW = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  vector_ls_sequencer_if #(.ADDR_W(AW), .RADDR_W(RW)) bus ();

  vector_ls_sequencer #(.ADDR_W(AW), .RADDR_W(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic st, input int base, input int rg, input int stride);
    bus.req_valid = 1'b1;
    bus.req_store = st;
    bus.req_base  = AW'(base);
    bus.req_reg   = RW'(rg);
`ifdef VLS_STRIDE_EN
    bus.req_stride = AW'(stride);
`else
    if (stride != 1) $display("note: stride %0d ignored, fixed stride build", stride);
`endif
  endtask

  task automatic scramble_inputs();
    bus.req_store = 1'($urandom);
    bus.req_base  = AW'($urandom);
    bus.req_reg   = RW'($urandom);
`ifdef VLS_STRIDE_EN
    bus.req_stride = AW'($urandom);
`endif
  endtask

  // Entered and left just after a negedge with the sequencer idle.
  task automatic run_req(input logic st, input int base, input int rg, input int stride_req);
    int stride;
    int sum;
    int exp_addr;
    bit exp_wrap;
`ifdef VLS_STRIDE_EN
    stride = stride_req;
`else
    stride = 1;
`endif
    exp_wrap = 1'b0;
    drive_req(st, base, rg, stride_req);
    chk("idle_ready", 32'(bus.req_ready), 32'd1);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'($urandom);
    scramble_inputs();
    for (int c = 0; c < 4; c++) begin
      sum      = base + c * stride;
      exp_addr = sum % (1 << AW);
      if (sum >= (1 << AW)) exp_wrap = 1'b1;
      chk("beat_col", 32'(bus.col_sel), 32'(c));
      chk("beat_ready", 32'(bus.req_ready), 32'd0);
      chk("beat_busy", 32'(bus.busy), 32'd1);
      chk("beat_done", 32'(bus.done), 32'd0);
      chk("beat_mwe", 32'(bus.mem_write_enable), 32'(st));
      chk("beat_rwe", 32'(bus.reg_write_enable), 32'(!st));
      chk("beat_wa", 32'(bus.mem_write_address), st ? 32'(exp_addr) : 32'd0);
      chk("beat_ra", 32'(bus.mem_read_address), st ? 32'd0 : 32'(exp_addr));
      chk("beat_rega", 32'(bus.reg_write_address), st ? 32'd0 : 32'(rg));
      @(negedge clk);
      scramble_inputs();
    end
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("done_wrap", 32'(bus.addr_wrap), 32'(exp_wrap));
    chk("done_mwe", 32'(bus.mem_write_enable), 32'd0);
    chk("done_rwe", 32'(bus.reg_write_enable), 32'd0);
    chk("done_col", 32'(bus.col_sel), 32'd0);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("post_done", 32'(bus.done), 32'd0);
    chk("post_ready", 32'(bus.req_ready), 32'd1);
    $display("req store=%0d base=%02h reg=%0d stride=%02h wrap=%0d", st, base, rg, stride, exp_wrap);
  endtask

  int   accepts[$];
  int   acc_cyc;
  int   acc_base;
  bit   have_acc;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_store = 1'b0;
    bus.req_base  = '0;
    bus.req_reg   = '0;
`ifdef VLS_STRIDE_EN
    bus.req_stride = '0;
`endif
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_mwe", 32'(bus.mem_write_enable), 32'd0);
    chk("rst_rwe", 32'(bus.reg_write_enable), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases: plain LD, plain ST, wrapping LD.
    run_req(1'b0, 'h10, 3, 1);
    run_req(1'b1, 'h20, 5, 1);
    run_req(1'b0, 'hFE, 7, 1);
`ifdef VLS_STRIDE_EN
    run_req(1'b1, 'h00, 2, 4);
    run_req(1'b0, 'hF0, 1, 'h40);
`endif

    for (int i = 0; i < 20; i++) begin
      run_req(1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 255)));
    end

    // Reset during the col = 1 beat aborts the operation.
    drive_req(1'b0, 'h40, 9, 1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("abort_col1", 32'(bus.col_sel), 32'd1);
    chk("abort_rwe_pre", 32'(bus.reg_write_enable), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_rwe", 32'(bus.reg_write_enable), 32'd0);
    chk("abort_mwe", 32'(bus.mem_write_enable), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_col", 32'(bus.col_sel), 32'd0);
    chk("abort_ra", 32'(bus.mem_read_address), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_nodone", 32'(bus.done), 32'd0);
      chk("abort_ready", 32'(bus.req_ready), 32'd1);
    end
    $display("req abort-on-reset base=40 reg=9");

    // req_valid held high: accepts every 6 cycles, later inputs do not corrupt beats.
    have_acc = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (have_acc && cyc > acc_cyc && cyc <= acc_cyc + 4)
        chk("b2b_addr", 32'(bus.mem_read_address), 32'((acc_base + cyc - acc_cyc - 1) % 256));
      drive_req(1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), 1);
      if (bus.req_ready) begin
        accepts.push_back(cyc);
        acc_cyc  = cyc;
        acc_base = int'(bus.req_base);
        have_acc = 1'b1;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    chk("b2b_count", 32'(accepts.size()), 32'd4);
    for (int i = 1; i < accepts.size(); i++)
      chk("b2b_gap", 32'(accepts[i] - accepts[i-1]), 32'd6);
    $display("req back-to-back accepts=%0d", accepts.size());
    repeat (8) @(negedge clk);
    chk("final_ready", 32'(bus.req_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
